// File: rtl/mac_dot_sequencer.sv
`timescale 1ns/1ps
// Operand-side controller for the 4-bit-scaled MAC: clears it, feeds VEC_LEN pairs, drains the pipeline,
// then rescales the accumulator to 16 bits. Define MAC_SEQ_SAT_EN to saturate instead of wrapping.
module mac_dot_sequencer #(
  parameter int VEC_LEN   = 8,
  parameter int PIPE_LAT  = 2,
  parameter int OUT_SHIFT = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        busy,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] a_data,
  input  logic [15:0] b_data,
  output logic        mac_rst,
  output logic        mac_ce,
  output logic [15:0] mac_a,
  output logic [15:0] mac_b,
  input  logic [31:0] mac_result,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic        out_sat
);

  localparam int CW = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
  localparam int DW = (PIPE_LAT > 0) ? $clog2(PIPE_LAT + 1) : 1;
  localparam logic [CW-1:0] LAST_PAIR = CW'(VEC_LEN - 1);
  localparam logic [DW-1:0] DRAIN_END = DW'(PIPE_LAT);

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_FEED, S_DRAIN, S_OUTPUT} state_t;

  state_t             state;
  logic [CW-1:0]      pair_cnt;
  logic [DW-1:0]      drain_cnt;
  logic signed [47:0] scaled;
  logic [15:0]        conv_data;

`ifdef MAC_SEQ_SAT_EN
  localparam logic signed [47:0] SAT_MAX = 48'sd32767;
  localparam logic signed [47:0] SAT_MIN = -48'sd32768;
  logic conv_sat;
  logic sat_q;
  assign out_sat = sat_q;
`else
  logic unused_scaled_hi;
  assign unused_scaled_hi = ^scaled[47:16];
  assign out_sat = 1'b0;
`endif

  always_comb begin
    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    scaled    = $signed({{16{mac_result[31]}}, mac_result}) <<< OUT_SHIFT;
    conv_data = scaled[15:0];
`ifdef MAC_SEQ_SAT_EN
    conv_sat = 1'b0;
    if (scaled > SAT_MAX) begin
      conv_data = 16'h7FFF;
      conv_sat  = 1'b1;
    end else if (scaled < SAT_MIN) begin
      conv_data = 16'h8000;
      conv_sat  = 1'b1;
    end
`endif
  end

  assign busy     = (state != S_IDLE);
  assign in_ready = (state == S_FEED);
  // The MAC clear follows reset directly so the accumulator is held cleared for the whole reset.
  assign mac_rst  = reset && (state != S_CLEAR);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      pair_cnt  <= '0;
      drain_cnt <= '0;
      mac_ce    <= 1'b0;
      mac_a     <= '0;
      mac_b     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
`ifdef MAC_SEQ_SAT_EN
      sat_q     <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments throughout, so every register samples pre-edge values;
      // mac_ce defaults low and only a FEED handshake raises it.
      mac_ce <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) state <= S_CLEAR;
        end
        S_CLEAR: begin
          pair_cnt <= '0;
          state    <= S_FEED;
        end
        S_FEED: begin
          if (in_valid) begin
            mac_a  <= a_data;
            mac_b  <= b_data;
            mac_ce <= 1'b1;
            if (pair_cnt == LAST_PAIR) begin
              pair_cnt  <= '0;
              drain_cnt <= '0;
              state     <= S_DRAIN;
            end else begin
              pair_cnt <= pair_cnt + 1'b1;
            end
          end
        end
        S_DRAIN: begin
          // The last product reaches the accumulator PIPE_LAT cycles after its ce pulse.
          if (drain_cnt == DRAIN_END) begin
            out_data  <= conv_data;
`ifdef MAC_SEQ_SAT_EN
            sat_q     <= conv_sat;
`endif
            out_valid <= 1'b1;
            state     <= S_OUTPUT;
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        S_OUTPUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mac_dot_sequencer.sv
`timescale 1ns/1ps
// Bench for mac_dot_sequencer: two instances (VEC_LEN 4 and 8), a behavioural MAC, a dot-product
// reference model checked every cycle, and hand-computed literal results.
module tb_mac_dot_sequencer;

  localparam int PIPE_LAT  = 2;
  localparam int OUT_SHIFT = 8;
  localparam int VL0       = 4;
  localparam int VL1       = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic        start[2], in_valid[2], out_ready[2];
  logic [15:0] a_data[2], b_data[2];
  logic        busy[2], in_ready[2], mac_rst[2], mac_ce[2], out_valid[2], out_sat[2];
  logic [15:0] mac_a[2], mac_b[2], out_data[2];
  logic [31:0] mac_result[2];

  int checks = 0;
  int errors = 0;

  mac_dot_sequencer #(.VEC_LEN(VL0), .PIPE_LAT(PIPE_LAT), .OUT_SHIFT(OUT_SHIFT)) u0 (
    .clk(clk), .reset(reset), .start(start[0]), .busy(busy[0]),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .a_data(a_data[0]), .b_data(b_data[0]),
    .mac_rst(mac_rst[0]), .mac_ce(mac_ce[0]), .mac_a(mac_a[0]), .mac_b(mac_b[0]),
    .mac_result(mac_result[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_data(out_data[0]), .out_sat(out_sat[0]));

  mac_dot_sequencer #(.VEC_LEN(VL1), .PIPE_LAT(PIPE_LAT), .OUT_SHIFT(OUT_SHIFT)) u1 (
    .clk(clk), .reset(reset), .start(start[1]), .busy(busy[1]),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .a_data(a_data[1]), .b_data(b_data[1]),
    .mac_rst(mac_rst[1]), .mac_ce(mac_ce[1]), .mac_a(mac_a[1]), .mac_b(mac_b[1]),
    .mac_result(mac_result[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_data(out_data[1]), .out_sat(out_sat[1]));

  function automatic logic signed [7:0] nib_prod(input logic [15:0] a, input logic [15:0] b);
    logic signed [7:0] na, nb;
    na = 8'(signed'(a[15:12]));
    nb = 8'(signed'(b[15:12]));
    return na * nb;
  endfunction

  // {sat, data} for a dot-product value, straight from the rescale rule.
  function automatic logic [16:0] ref_conv(input longint acc);
    longint v;
    v = acc * (longint'(1) << OUT_SHIFT);
`ifdef MAC_SEQ_SAT_EN
    if (v > 32767)  return {1'b1, 16'h7FFF};
    if (v < -32768) return {1'b1, 16'h8000};
`endif
    return {1'b0, v[15:0]};
  endfunction

  // Behavioural MAC: synchronous clear, product registered, then accumulated (PIPE_LAT = 2).
  logic signed [7:0] mac_prod[2];
  logic              mac_pv[2];
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!mac_rst[i]) begin
        mac_result[i] <= '0;
        mac_prod[i]   <= '0;
        mac_pv[i]     <= 1'b0;
      end else begin
        mac_pv[i]   <= mac_ce[i];
        mac_prod[i] <= nib_prod(mac_a[i], mac_b[i]);
        if (mac_pv[i]) mac_result[i] <= mac_result[i] + {{24{mac_prod[i][7]}}, mac_prod[i]};
      end
    end
  end

  // Reference model: transaction-level view of a dot product.
  logic        m_busy[2], m_clear[2], m_feed[2], m_ce[2], m_ov[2], m_os[2];
  logic [15:0] m_a[2], m_b[2], m_od[2];
  int          m_cnt[2], m_wait[2];
  longint      m_sum[2];

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        m_busy[i] <= 1'b0; m_clear[i] <= 1'b0; m_feed[i] <= 1'b0; m_ce[i] <= 1'b0;
        m_ov[i] <= 1'b0; m_os[i] <= 1'b0; m_od[i] <= '0; m_a[i] <= '0; m_b[i] <= '0;
        m_cnt[i] <= 0; m_wait[i] <= 0; m_sum[i] <= 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        automatic int vl = (i == 0) ? VL0 : VL1;
        automatic logic [16:0] r = ref_conv(m_sum[i]);
        m_ce[i] <= 1'b0;
        if (!m_busy[i] && start[i]) begin
          m_busy[i]  <= 1'b1;
          m_clear[i] <= 1'b1;
        end
        if (m_clear[i]) begin
          m_clear[i] <= 1'b0;
          m_feed[i]  <= 1'b1;
          m_cnt[i]   <= 0;
          m_sum[i]   <= 0;
        end
        if (m_feed[i] && in_valid[i]) begin
          m_ce[i]  <= 1'b1;
          m_a[i]   <= a_data[i];
          m_b[i]   <= b_data[i];
          m_sum[i] <= m_sum[i] + longint'(nib_prod(a_data[i], b_data[i]));
          m_cnt[i] <= m_cnt[i] + 1;
          if (m_cnt[i] + 1 == vl) begin
            m_feed[i] <= 1'b0;
            m_wait[i] <= PIPE_LAT + 1;
          end
        end
        if (m_wait[i] > 0) begin
          m_wait[i] <= m_wait[i] - 1;
          if (m_wait[i] == 1) begin
            m_ov[i] <= 1'b1;
            m_od[i] <= r[15:0];
            m_os[i] <= r[16];
          end
        end
        if (m_ov[i] && out_ready[i]) begin
          m_ov[i]   <= 1'b0;
          m_busy[i] <= 1'b0;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, sampled on the falling edge.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!reset) begin
        check($sformatf("u%0d rst busy", i), busy[i], 0);
        check($sformatf("u%0d rst mac_rst", i), mac_rst[i], 0);
        check($sformatf("u%0d rst out_valid", i), out_valid[i], 0);
      end else begin
        check($sformatf("u%0d busy", i), busy[i], m_busy[i]);
        check($sformatf("u%0d in_ready", i), in_ready[i], m_feed[i]);
        check($sformatf("u%0d mac_rst", i), mac_rst[i], !m_clear[i]);
        check($sformatf("u%0d mac_ce", i), mac_ce[i], m_ce[i]);
        check($sformatf("u%0d out_valid", i), out_valid[i], m_ov[i]);
        if (m_ce[i]) begin
          check($sformatf("u%0d mac_a", i), mac_a[i], m_a[i]);
          check($sformatf("u%0d mac_b", i), mac_b[i], m_b[i]);
        end
        if (m_ov[i]) begin
          check($sformatf("u%0d out_data", i), out_data[i], m_od[i]);
          check($sformatf("u%0d out_sat", i), out_sat[i], m_os[i]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int i);
    start[i] = 1'b1;
    tick();
    start[i] = 1'b0;
  endtask

  task automatic wait_ready(input int i);
    int n = 0;
    while (in_ready[i] !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check("in_ready rises", in_ready[i], 1);
  endtask

  // n pairs of (a, b); gap idle cycles between pairs; start pulsed alongside pair poke_at.
  task automatic feed(input int i, input logic [15:0] a, input logic [15:0] b, input int n,
                      input int gap, input int poke_at);
    for (int k = 0; k < n; k++) begin
      a_data[i]   = a;
      b_data[i]   = b;
      in_valid[i] = 1'b1;
      if (k == poke_at) start[i] = 1'b1;
      tick();
      in_valid[i] = 1'b0;
      start[i]    = 1'b0;
      if (k < n - 1) repeat (gap) tick();
    end
  endtask

  task automatic collect(input int i, input int stall, input int exp_lat,
                         input logic [15:0] exp_d, input logic exp_s, input bit poke_start);
    int k = 0;
    while (out_valid[i] !== 1'b1 && k < 64) begin
      tick();
      k++;
    end
    if (exp_lat >= 0) check("out_valid latency", k, exp_lat);
    check("out_valid seen", out_valid[i], 1);
    check("result data", out_data[i], exp_d);
    check("result sat", out_sat[i], exp_s);
    for (int s = 0; s < stall; s++) begin
      if (poke_start && s == 0) start[i] = 1'b1;
      tick();
      start[i] = 1'b0;
      check("stall valid held", out_valid[i], 1);
      check("stall data held", out_data[i], exp_d);
    end
    out_ready[i] = 1'b1;
    if (poke_start) start[i] = 1'b1;
    tick();
    out_ready[i] = 1'b0;
    start[i]     = 1'b0;
    check("busy clears", busy[i], 0);
    check("out_valid clears", out_valid[i], 0);
    if (poke_start) begin
      tick();
      check("no restart busy", busy[i], 0);
      check("no restart mac_rst", mac_rst[i], 1);
    end
  endtask

`ifdef MAC_SEQ_SAT_EN
  localparam logic [15:0] T2_D = 16'h7FFF;
  localparam logic        T2_S = 1'b1;
  localparam logic [15:0] T3_D = 16'h8000;
  localparam logic        T3_S = 1'b1;
`else
  localparam logic [15:0] T2_D = 16'h8800;
  localparam logic        T2_S = 1'b0;
  localparam logic [15:0] T3_D = 16'h4000;
  localparam logic        T3_S = 1'b0;
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      start[i] = 1'b0; in_valid[i] = 1'b0; out_ready[i] = 1'b0;
      a_data[i] = '0;  b_data[i] = '0;
    end
    #12;
    check("reset busy", busy[0], 0);
    check("reset in_ready", in_ready[0], 0);
    check("reset mac_rst", mac_rst[0], 0);
    check("reset mac_ce", mac_ce[0], 0);
    check("reset mac_a", mac_a[0], 0);
    check("reset out_valid", out_valid[0], 0);
    check("reset out_data", out_data[0], 0);
    check("reset out_sat", out_sat[0], 0);
    #10 reset = 1'b1;
    tick();
    check("idle mac_rst", mac_rst[0], 1);

    // 1: 4 x (2*3) = 24 -> 24 << 8 = 0x1800
    do_start(0);
    wait_ready(0);
    feed(0, 16'h2000, 16'h3000, 4, 0, -1);
    collect(0, 0, PIPE_LAT + 1, 16'h1800, 1'b0, 1'b0);

    // 2: 8 x (7*7) = 392
    do_start(1);
    wait_ready(1);
    feed(1, 16'h7000, 16'h7000, 8, 0, -1);
    collect(1, 0, PIPE_LAT + 1, T2_D, T2_S, 1'b0);

    // 3: 8 x (-8*7) = -448
    do_start(1);
    wait_ready(1);
    feed(1, 16'h8000, 16'h7000, 8, 0, -1);
    collect(1, 0, PIPE_LAT + 1, T3_D, T3_S, 1'b0);

    // 4: valid pattern 1,0,0,1,... and 5 cycles of output backpressure
    do_start(0);
    wait_ready(0);
    feed(0, 16'h2000, 16'h3000, 4, 2, -1);
    collect(0, 5, PIPE_LAT + 1, 16'h1800, 1'b0, 1'b0);

    // 5: start during FEED, OUTPUT and on the output handshake is ignored
    do_start(0);
    wait_ready(0);
    feed(0, 16'h2000, 16'h3000, 4, 0, 1);
    collect(0, 2, PIPE_LAT + 1, 16'h1800, 1'b0, 1'b1);
    // fresh run: 4 x (1*1) = 4 -> 0x0400, nothing carried over
    do_start(0);
    check("clear cycle mac_rst", mac_rst[0], 0);
    tick();
    check("clear lasts one cycle", mac_rst[0], 1);
    wait_ready(0);
    feed(0, 16'h1000, 16'h1000, 4, 0, -1);
    collect(0, 0, PIPE_LAT + 1, 16'h0400, 1'b0, 1'b0);

    // 6: asynchronous reset mid-FEED
    do_start(0);
    wait_ready(0);
    a_data[0] = 16'h2000;
    b_data[0] = 16'h3000;
    in_valid[0] = 1'b1;
    tick();
    tick();
    #2 reset = 1'b0;
    #1;
    check("async rst mac_ce", mac_ce[0], 0);
    check("async rst busy", busy[0], 0);
    check("async rst in_ready", in_ready[0], 0);
    check("async rst out_valid", out_valid[0], 0);
    check("async rst mac_rst", mac_rst[0], 0);
    in_valid[0] = 1'b0;
    tick();
    tick();
    #2 reset = 1'b1;
    tick();
    check("post reset busy", busy[0], 0);
    do_start(0);
    wait_ready(0);
    feed(0, 16'h2000, 16'h3000, 4, 0, -1);
    collect(0, 0, PIPE_LAT + 1, 16'h1800, 1'b0, 1'b0);

    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mac_dot_sequencer.md
Name: mac_dot_sequencer

Overview:
Initiator/controller on the operand side of the 4-bit-scaled MAC accumulator.
- Accepts a stream of signed 16-bit operand pairs over a valid/ready handshake.
- Drives the MAC's clear, clock-enable and operand ports for one dot product of VEC_LEN pairs.
- Waits out the MAC pipeline, then reads back the 32-bit accumulator.
- Rescales and saturates the result to signed 16 bits and presents it on a valid/ready output.

Parameters:
- VEC_LEN, 8, number of operand pairs per dot product (>=1).
- PIPE_LAT, 2, cycles from mac_ce high to the accumulator reflecting that product.
- OUT_SHIFT, 8, left shift applied to mac_result before the 16-bit output conversion.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a dot product when idle.
- busy  out  1  high from the start acceptance until the output handshake completes.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  high only in FEED.
- a_data  in  16  signed operand A.
- b_data  in  16  signed operand B.
- mac_rst  out  1  active-low accumulator clear to the MAC.
- mac_ce  out  1  MAC clock enable, registered.
- mac_a  out  16  registered operand A to the MAC.
- mac_b  out  16  registered operand B to the MAC.
- mac_result  in  32  signed accumulator value from the MAC.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_data  out  16  signed rescaled result.
- out_sat  out  1  out_data was clipped.

Behaviour:
- Reset (asynchronous, reset=0):
  - FSM goes to IDLE.
  - mac_rst=0 (MAC accumulator cleared while reset is held).
  - mac_ce=0, mac_a=0, mac_b=0.
  - out_valid=0, out_data=0, out_sat=0, busy=0, in_ready=0.
  - All counters are set to 0.
- Reset mid-operation: all state is abandoned immediately with no output. After release the block is in IDLE.
- Outside reset, mac_rst=1 except in CLEAR.
- IDLE:
  - When start=1, go to CLEAR and set busy=1.
  - start is ignored in every other state.
- CLEAR:
  - Lasts exactly 1 cycle, with mac_rst=0 and mac_ce=0, so the synchronous clear lands.
  - Then go to FEED with pair counter=0.
- FEED:
  - in_ready=1.
  - On each edge with in_valid && in_ready: mac_a<=a_data, mac_b<=b_data, mac_ce<=1, and the counter increments.
  - Otherwise mac_ce<=0. Stalls insert ce=0 bubbles, and the MAC holds its accumulation.
  - On the VEC_LEN-th handshake (edge E), go to DRAIN. in_ready drops the cycle after E.
- DRAIN:
  - mac_ce<=0.
  - Wait so that mac_result is sampled at edge E+PIPE_LAT+1.
  - At that edge, out_data and out_sat are registered, out_valid<=1, and the FSM goes to OUTPUT.
- OUTPUT:
  - out_valid, out_data and out_sat are held stable until out_ready=1.
  - On the handshake edge: out_valid<=0, busy<=0, return to IDLE.
  - out_ready while out_valid=0 has no effect.
  - start arriving in the same cycle as the output handshake is ignored.
- Arithmetic:
  - s = mac_result sign-extended to 48 bits, then shifted arithmetically left by OUT_SHIFT.
  - Conversion of s to 16 bits is defined under the optional feature.
- Backpressure: out_data is never updated while out_valid=1 and out_ready=0.

Optional Feature:
Macro MAC_SEQ_SAT_EN.
- Defined:
  - s>32767 gives out_data=0x7FFF and out_sat=1.
  - s<-32768 gives out_data=0x8000 and out_sat=1.
  - Otherwise out_data=s[15:0] and out_sat=0.
- Undefined:
  - out_data=s[15:0], i.e. two's-complement wrap.
  - out_sat is tied to 0 and the comparison logic is not built.

Test Plan:
1. VEC_LEN=4, four pairs a=0x2000, b=0x3000 (nibbles 2*3), modelled MAC -> mac_result=24, out_data=0x1800, out_sat=0. out_valid rises exactly PIPE_LAT+1 cycles after the 4th handshake.
2. VEC_LEN=8, eight pairs 0x7000/0x7000 -> mac_result=392 -> with MAC_SEQ_SAT_EN: out_data=0x7FFF, out_sat=1; without: out_data=0x8800, out_sat=0.
3. VEC_LEN=8, eight pairs a=0x8000, b=0x7000 -> mac_result=-448 -> with MAC_SEQ_SAT_EN: out_data=0x8000, out_sat=1.
4. in_valid toggled 1,0,0,1,... during FEED, plus out_ready held 0 for 5 cycles -> mac_ce pulses only on handshakes and the result matches test 1. out_data and out_valid stay stable through the stall, and busy clears on the handshake.
5. start pulsed during FEED and OUTPUT -> no restart and the counter is unaffected. A second start after completion -> mac_rst low for exactly 1 cycle and a fresh result, with no carry-over from the previous accumulation.
6. reset asserted asynchronously mid-FEED (between edges) -> mac_ce, busy, in_ready and out_valid go to 0 at once, and mac_rst=0. After release plus start, a full vector gives the test-1 result.
